// File: rtl/chia_4bit_if.sv
// Start/done handshake bundle for the 8/4 restoring divider.
// The master drives operands; the slave returns results.
interface chia_4bit_if;
    logic       start;
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] q;
    logic [3:0] r;
    logic       busy;
    logic       done;
    logic       div0;

    modport master (
        output start, a, b,
        input  q, r, busy, done, div0
    );

    modport slave (
        input  start, a, b,
        output q, r, busy, done, div0
    );
endinterface

// File: rtl/chia_4bit.sv
// Sequential restoring divider: 8-bit dividend / 4-bit divisor.
// One quotient bit per clock, MSB first; inverse of the 4x4 multiplier.
module chia_4bit (
    input  logic        clk,
    input  logic        rst,
    chia_4bit_if.slave  bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t     state_q;
    logic [7:0] dvd_q;
    logic [3:0] pr_q;
    logic [3:0] dvs_q;
    logic [2:0] cnt_q;
    logic [7:0] q_q;
    logic [3:0] r_q;
    logic       busy_q;
    logic       done_q;
    logic       div0_q;

    logic [4:0] t_d;
    logic       ge_d;
    logic [3:0] pr_d;
    logic [7:0] dvd_d;

    // The 5-bit partial remainder only exists as t; after each step it is
    // below the divisor, so four stored bits are enough.
    always_comb begin
        t_d   = {pr_q, dvd_q[7]};
        ge_d  = t_d >= {1'b0, dvs_q};
        pr_d  = ge_d ? (t_d[3:0] - dvs_q) : t_d[3:0];
        dvd_d = {dvd_q[6:0], ge_d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            pr_q    <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            div0_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.b == 4'd0) begin
                            q_q    <= 8'hFF;
                            r_q    <= bus.a[3:0];
                            div0_q <= 1'b1;
                            done_q <= 1'b1;
                        end else begin
                            dvd_q   <= bus.a;
                            pr_q    <= '0;
                            cnt_q   <= 3'd7;
                            dvs_q   <= bus.b;
                            div0_q  <= 1'b0;
                            busy_q  <= 1'b1;
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    // Quotient bits shift into the vacated dividend LSBs.
                    dvd_q <= dvd_d;
                    pr_q  <= pr_d;
                    cnt_q <= cnt_q - 3'd1;
                    if (cnt_q == 3'd0) begin
                        q_q     <= dvd_d;
                        r_q     <= pr_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.q    = q_q;
    assign bus.r    = r_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.div0 = div0_q;
endmodule
